// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered ALU operand select with EX/MEM forwarding
// One-entry pipeline register: operands are resolved combinationally and captured on handshake.
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 21,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             alu_src,
    input  logic             a_sel,
    input  logic [1:0]       imm_mode,
    input  logic [RA_W-1:0]  rs1_addr,
    input  logic [RA_W-1:0]  rs2_addr,
    input  logic [XLEN-1:0]  reg_out1,
    input  logic [XLEN-1:0]  reg_out2,
    input  logic [XLEN-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_wen,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_wen,
    input  logic [XLEN-1:0]  mem_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    output logic [XLEN-1:0]  store_data,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_X0  = 2'd3;

    logic            r_out_valid;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_store_data;
    logic [1:0]      r_fwd_a;
    logic [1:0]      r_fwd_b;

    logic            w_capture;
    logic [1:0]      w_code_a;
    logic [1:0]      w_code_b;
    logic [XLEN-1:0] w_val_a;
    logic [XLEN-1:0] w_val_b;
    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_ext_imm;

    // x0 wins outright; EX is younger than MEM so it takes priority
    function automatic logic [1:0] fwd_code(
        input logic [RA_W-1:0] addr,
        input logic            e_wen,
        input logic [RA_W-1:0] e_rd,
        input logic            m_wen,
        input logic [RA_W-1:0] m_rd
    );
        if (addr == '0)                  return FWD_X0;
        else if (e_wen && (e_rd == addr)) return FWD_EX;
        else if (m_wen && (m_rd == addr)) return FWD_MEM;
        else                              return FWD_RF;
    endfunction

    assign w_code_a = fwd_code(rs1_addr, ex_wen, ex_rd, mem_wen, mem_rd);
    assign w_code_b = fwd_code(rs2_addr, ex_wen, ex_rd, mem_wen, mem_rd);

    always_comb begin
        w_val_a = reg_out1;
        case (w_code_a)
            FWD_EX:  w_val_a = ex_result;
            FWD_MEM: w_val_a = mem_result;
            FWD_X0:  w_val_a = '0;
            default: w_val_a = reg_out1;
        endcase
    end

    always_comb begin
        w_val_b = reg_out2;
        case (w_code_b)
            FWD_EX:  w_val_b = ex_result;
            FWD_MEM: w_val_b = mem_result;
            FWD_X0:  w_val_b = '0;
            default: w_val_b = reg_out2;
        endcase
    end

    assign w_sext = XLEN'($signed(imm));

    always_comb begin
        w_ext_imm = w_sext;
        case (imm_mode)
            2'd1:    w_ext_imm = XLEN'(imm);
            2'd2:    w_ext_imm = w_sext << 12;
            2'd3:    w_ext_imm = w_sext << 1;
            default: w_ext_imm = w_sext;
        endcase
    end

    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_out_valid <= 1'b0;
        else if (flush)       r_out_valid <= 1'b0;
        else if (in_ready)    r_out_valid <= in_valid;
    end

    // Data registers only move on capture, so they hold during a stall and stay stale after flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_store_data <= '0;
            r_fwd_a      <= '0;
            r_fwd_b      <= '0;
        end else if (w_capture) begin
            r_op_a       <= a_sel ? pc : w_val_a;
            r_op_b       <= alu_src ? w_ext_imm : w_val_b;
            r_store_data <= w_val_b;
            r_fwd_a      <= w_code_a;
            r_fwd_b      <= w_code_b;
        end
    end

    assign out_valid  = r_out_valid;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign store_data = r_store_data;
    assign fwd_a      = r_fwd_a;
    assign fwd_b      = r_fwd_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
// Stimulus pushes expected operands computed arithmetically; a negedge monitor compares.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, alu_src, a_sel;
    logic [1:0]  imm_mode;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd, mem_rd;
    logic [31:0] reg_out1, reg_out2, pc, ex_result, mem_result;
    logic [20:0] imm;
    logic        ex_wen, mem_wen;
    logic        out_valid, out_ready;
    logic [31:0] op_a, op_b, store_data;
    logic [1:0]  fwd_a, fwd_b;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    exp_t q[$];
    bit   m_full = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .alu_src(alu_src), .a_sel(a_sel), .imm_mode(imm_mode),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .reg_out1(reg_out1),
        .reg_out2(reg_out2), .pc(pc), .imm(imm), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_wen(mem_wen),
        .mem_result(mem_result), .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .store_data(store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void ref_src(input logic [4:0] addr, input logic [31:0] rv,
                                    output logic [31:0] v, output logic [1:0] c);
        if (addr == 0) begin v = 0; c = 3; end
        else if (ex_wen && ex_rd == addr) begin v = ex_result; c = 1; end
        else if (mem_wen && mem_rd == addr) begin v = mem_result; c = 2; end
        else begin v = rv; c = 0; end
    endfunction

    function automatic logic [31:0] ref_imm(input logic [20:0] im, input logic [1:0] mode);
        longint v;
        v = longint'(im);
        if (im[20]) v = v - (longint'(1) << 21);
        case (mode)
            2'd1: v = longint'(im);
            2'd2: v = v * 4096;
            2'd3: v = v * 2;
            default: ;
        endcase
        return v[31:0];
    endfunction

    // One clock: model the handshake at the edge using only bench-driven signals
    task automatic step();
        exp_t e;
        logic [31:0] va, vb;
        logic [1:0]  ca, cb;
        bit accept;
        @(posedge clk);
        accept = in_valid && !flush && (!m_full || out_ready);
        if (m_full && !out_ready && flush && q.size() > 0) void'(q.pop_front());
        if (accept) begin
            ref_src(rs1_addr, reg_out1, va, ca);
            ref_src(rs2_addr, reg_out2, vb, cb);
            e.a  = a_sel ? pc : va;
            e.b  = alu_src ? ref_imm(imm, imm_mode) : vb;
            e.sd = vb;
            e.fa = ca;
            e.fb = cb;
            q.push_back(e);
        end
        m_full = accept || (m_full && !out_ready && !flush);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_full));
            check("in_ready", 32'(in_ready), 32'(!m_full || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: out_valid with no expected entry at %0t", $time);
                end else begin
                    check("op_a", op_a, q[0].a);
                    check("op_b", op_b, q[0].b);
                    check("store_data", store_data, q[0].sd);
                    check("fwd_a", 32'(fwd_a), 32'(q[0].fa));
                    check("fwd_b", 32'(fwd_b), 32'(q[0].fb));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_store_data", store_data, 0);
        check("rst_fwd", {28'd0, fwd_a, fwd_b}, 0);
    endtask

    task automatic quiet();
        in_valid = 0; flush = 0; alu_src = 0; a_sel = 0; imm_mode = 0;
        rs1_addr = 1; rs2_addr = 2; reg_out1 = 0; reg_out2 = 0; pc = 0; imm = 0;
        ex_rd = 0; ex_wen = 0; ex_result = 0; mem_rd = 0; mem_wen = 0; mem_result = 0;
        out_ready = 1;
    endtask

    initial begin
        rst_n = 0;
        quiet();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // operand B source select
        reg_out2 = 15; imm = 20; in_valid = 1;
        alu_src = 0; step();
        alu_src = 1; step();
        in_valid = 0; step(); step();

        // forwarding priority
        rs1_addr = 5; ex_rd = 5; ex_wen = 1; ex_result = 32'hAA;
        mem_rd = 5; mem_wen = 1; mem_result = 32'hBB; reg_out1 = 32'h11; in_valid = 1;
        step();
        ex_wen = 0; step();
        rs1_addr = 0; step();
        a_sel = 1; pc = 32'h1000; step();
        a_sel = 0; mem_wen = 0; rs1_addr = 1;

        // immediate extension modes
        imm = 21'h1FFFFF; alu_src = 1;
        for (int m = 0; m < 4; m++) begin imm_mode = 2'(m); step(); end
        imm = 21'h0ABCDE;
        for (int m = 0; m < 4; m++) begin imm_mode = 2'(m); step(); end
        in_valid = 0; step();

        // stall with new instructions waiting
        in_valid = 1; out_ready = 1; imm = 21'd100; imm_mode = 0; step();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin imm = 21'(200 + k); step(); end
        out_ready = 1; imm = 21'd300; step();
        in_valid = 0; step(); step();

        // flush with held output and incoming instruction
        in_valid = 1; out_ready = 0; imm = 21'd7; step();
        flush = 1; imm = 21'd8; step();
        flush = 0; in_valid = 0; out_ready = 1; step(); step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            alu_src    = 1'($urandom);
            a_sel      = 1'($urandom);
            imm_mode   = 2'($urandom);
            rs1_addr   = 5'($urandom_range(0, 3));
            rs2_addr   = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            mem_rd     = 5'($urandom_range(0, 3));
            ex_wen     = 1'($urandom);
            mem_wen    = 1'($urandom);
            reg_out1   = $urandom; reg_out2 = $urandom; pc = $urandom;
            ex_result  = $urandom; mem_result = $urandom;
            imm        = 21'($urandom);
            step();
        end
        quiet();
        step(); step();
        check("drained", 32'(q.size()), 0);

        // asynchronous reset while holding an output
        in_valid = 1; out_ready = 0; rs1_addr = 3; reg_out1 = 32'h5A5A; step(); step();
        #2 rst_n = 0;
        #1;
        check_reset_outputs();
        q.delete();
        m_full = 0;
        in_valid = 0; out_ready = 0;
        @(posedge clk);
        #1 rst_n = 1;
        #1 check("in_ready_after_rst", 32'(in_ready), 1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
